// File: rtl/l1_l2_arb_pkg.sv
// rtl/l1_l2_arb_pkg.sv - shared types and line opcodes for the L1-to-L2 request arbiter
package l1_l2_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_ISSUE    = 2'd1,
      ARB_WAIT_RSP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   // Line opcodes understood by the L1s and the L2
   localparam logic [3:0] MEM_LD_CL = 4'd7;
   localparam logic [3:0] MEM_ST_CL = 4'd8;

endpackage

// File: rtl/l1_l2_req_arb.sv
// rtl/l1_l2_req_arb.sv - round-robin I/D arbiter for the single outstanding L1-to-L2 line request
module l1_l2_req_arb
   import l1_l2_arb_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int CL_W   = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              l1i_req,
   input  logic [ADDR_W-1:0] l1i_addr,
   output logic              l1i_ack,
   output logic              l1i_rsp_valid,
   input  logic              l1d_req,
   input  logic [ADDR_W-1:0] l1d_addr,
   input  logic [3:0]        l1d_opcode,
   input  logic [CL_W-1:0]   l1d_store_data,
   output logic              l1d_ack,
   output logic              l1d_rsp_valid,
   output logic [CL_W-1:0]   l1_rsp_data,
   output logic              l2_req_valid,
   output logic [ADDR_W-1:0] l2_req_addr,
   output logic [3:0]        l2_req_opcode,
   output logic [CL_W-1:0]   l2_req_store_data,
   input  logic              l2_req_ready,
   input  logic              l2_rsp_valid,
   input  logic [CL_W-1:0]   l2_rsp_data,
   input  logic              flush_hold,
   output logic              arb_idle,
   output logic              proto_err,
   output logic [31:0]       grants_i,
   output logic [31:0]       grants_d
);

   arb_state_t state;
   arb_owner_t owner;
   arb_owner_t last_grant;
   arb_owner_t pick;

   // On a tie the side that did not win last time takes the grant
   function automatic arb_owner_t rr_pick(input logic req_i, input logic req_d,
                                          input arb_owner_t last);
      if (req_i && req_d)
         return (last == OWN_I) ? OWN_D : OWN_I;
      else if (req_d)
         return OWN_D;
      else
         return OWN_I;
   endfunction

   assign pick = rr_pick(l1i_req, l1d_req, last_grant);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= ARB_IDLE;
         owner             <= OWN_I;
         last_grant        <= OWN_I;
         l1i_ack           <= 1'b0;
         l1d_ack           <= 1'b0;
         l2_req_addr       <= '0;
         l2_req_opcode     <= '0;
         l2_req_store_data <= '0;
         proto_err         <= 1'b0;
         grants_i          <= '0;
         grants_d          <= '0;
      end else begin
         l1i_ack <= 1'b0;
         l1d_ack <= 1'b0;
         if (l2_rsp_valid && state != ARB_WAIT_RSP)
            proto_err <= 1'b1;
         case (state)
            ARB_IDLE: begin
               if (!flush_hold && (l1i_req || l1d_req)) begin
                  owner      <= pick;
                  last_grant <= pick;
                  state      <= ARB_ISSUE;
                  if (pick == OWN_D) begin
                     l1d_ack           <= 1'b1;
                     l2_req_addr       <= l1d_addr;
                     l2_req_opcode     <= l1d_opcode;
                     l2_req_store_data <= l1d_store_data;
                     grants_d          <= grants_d + 32'd1;
                  end else begin
                     l1i_ack           <= 1'b1;
                     l2_req_addr       <= l1i_addr;
                     l2_req_opcode     <= MEM_LD_CL;
                     l2_req_store_data <= '0;
                     grants_i          <= grants_i + 32'd1;
                  end
               end
            end
            ARB_ISSUE: begin
               if (l2_req_ready)
                  state <= ARB_WAIT_RSP;
            end
            ARB_WAIT_RSP: begin
               if (l2_rsp_valid)
                  state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign l2_req_valid  = (state == ARB_ISSUE);
   assign arb_idle      = (state == ARB_IDLE);
   assign l1i_rsp_valid = (state == ARB_WAIT_RSP) && (owner == OWN_I) && l2_rsp_valid;
   assign l1d_rsp_valid = (state == ARB_WAIT_RSP) && (owner == OWN_D) && l2_rsp_valid;
   assign l1_rsp_data   = l2_rsp_data;

endmodule

// File: tb/tb_l1_l2_req_arb.sv
// tb/tb_l1_l2_req_arb.sv - scoreboard bench for the L1-to-L2 request arbiter
module tb_l1_l2_req_arb;
   import l1_l2_arb_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          l1i_req, l1d_req;
   logic [63:0]   l1i_addr, l1d_addr;
   logic [3:0]    l1d_opcode;
   logic [127:0]  l1d_store_data;
   logic          l1i_ack, l1d_ack, l1i_rsp_valid, l1d_rsp_valid;
   logic [127:0]  l1_rsp_data;
   logic          l2_req_valid;
   logic [63:0]   l2_req_addr;
   logic [3:0]    l2_req_opcode;
   logic [127:0]  l2_req_store_data;
   logic          l2_req_ready, l2_rsp_valid;
   logic [127:0]  l2_rsp_data;
   logic          flush_hold, arb_idle, proto_err;
   logic [31:0]   grants_i, grants_d;

   typedef struct {
      logic         side;
      logic [63:0]  addr;
      logic [3:0]   op;
      logic [127:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   l1_l2_req_arb #(.ADDR_W(64), .CL_W(128)) dut (
      .clk(clk), .reset(reset),
      .l1i_req(l1i_req), .l1i_addr(l1i_addr), .l1i_ack(l1i_ack), .l1i_rsp_valid(l1i_rsp_valid),
      .l1d_req(l1d_req), .l1d_addr(l1d_addr), .l1d_opcode(l1d_opcode),
      .l1d_store_data(l1d_store_data), .l1d_ack(l1d_ack), .l1d_rsp_valid(l1d_rsp_valid),
      .l1_rsp_data(l1_rsp_data),
      .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_opcode(l2_req_opcode),
      .l2_req_store_data(l2_req_store_data), .l2_req_ready(l2_req_ready),
      .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
      .flush_hold(flush_hold), .arb_idle(arb_idle), .proto_err(proto_err),
      .grants_i(grants_i), .grants_d(grants_d)
   );

   function automatic exp_t mk_exp(input logic side, input logic [63:0] addr,
                                   input logic [3:0] op, input logic [127:0] data);
      exp_t e;
      e.side = side; e.addr = addr; e.op = op; e.data = data;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      l1i_req = 0; l1d_req = 0; l1i_addr = '0; l1d_addr = '0;
      l1d_opcode = '0; l1d_store_data = '0;
      l2_req_ready = 0; l2_rsp_valid = 0; l2_rsp_data = '0; flush_hold = 0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Returns the number of negedges until an ack appears (bounded)
   task automatic wait_ack(output logic side_d, output int lat, output bit to);
      to = 1'b1; lat = 0; side_d = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (l1i_ack || l1d_ack) begin
            side_d = l1d_ack; lat = c; to = 1'b0;
            break;
         end
      end
   endtask

   // Called from the negedge of the first ISSUE cycle
   task automatic complete(input int rdy_dly, input logic [127:0] rdata,
                           output logic ri, output logic rd, output logic [127:0] rdat);
      repeat (rdy_dly) @(negedge clk);
      l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0;
      l2_rsp_valid = 1'b1;
      l2_rsp_data  = rdata;
      #1;
      ri = l1i_rsp_valid; rd = l1d_rsp_valid; rdat = l1_rsp_data;
      tick();
      l2_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      @(negedge clk);
      n_cmp++;
      if ({arb_idle, l1i_ack, l1d_ack, l2_req_valid, l1i_rsp_valid, l1d_rsp_valid, proto_err} !== 7'b1000000) begin
         n_bad++;
         $display("FAIL reset_strobes: idle/acki/ackd/reqv/rspi/rspd/perr=%b want 1000000",
                  {arb_idle, l1i_ack, l1d_ack, l2_req_valid, l1i_rsp_valid, l1d_rsp_valid, proto_err});
      end
      n_cmp++;
      if (grants_i !== 0 || grants_d !== 0 || l2_req_addr !== 0 || l2_req_opcode !== 0 || l2_req_store_data !== 0) begin
         n_bad++;
         $display("FAIL reset_fields: gi=%0d gd=%0d addr=%h op=%h want all 0", grants_i, grants_d, l2_req_addr, l2_req_opcode);
      end
   endtask

   task automatic test_single_i();
      logic sd, ri, rd;
      int lat;
      bit to;
      logic [127:0] rdat;
      exp_t e;
      tick();
      l1i_req = 1'b1; l1i_addr = 64'h1000;
      sb.push_back(mk_exp(1'b0, 64'h1000, MEM_LD_CL, '0));
      wait_ack(sd, lat, to);
      l1i_req = 1'b0;
      n_cmp++;
      if (to || sd !== 1'b0 || lat != 2) begin
         n_bad++;
         $display("FAIL single_i_ack: side=%0d lat=%0d timeout=%0d want side=0 lat=2", sd, lat, to);
      end
      e = sb.pop_front();
      n_cmp++;
      if (l2_req_valid !== 1'b1 || l2_req_addr !== e.addr || l2_req_opcode !== e.op || l2_req_store_data !== e.data) begin
         n_bad++;
         $display("FAIL single_i_req: v=%b addr=%h op=%h data=%h want v=1 addr=%h op=%h data=%h",
                  l2_req_valid, l2_req_addr, l2_req_opcode, l2_req_store_data, e.addr, e.op, e.data);
      end
      complete(0, {16{8'hAB}}, ri, rd, rdat);
      n_cmp++;
      if (ri !== 1'b1 || rd !== 1'b0 || rdat !== {16{8'hAB}}) begin
         n_bad++;
         $display("FAIL single_i_rsp: rspi=%b rspd=%b data=%h want 1 0 %h", ri, rd, rdat, {16{8'hAB}});
      end
      n_cmp++;
      if (grants_i !== 32'd1 || grants_d !== 32'd0 || arb_idle !== 1'b1) begin
         n_bad++;
         $display("FAIL single_i_count: gi=%0d gd=%0d idle=%b want 1 0 1", grants_i, grants_d, arb_idle);
      end
   endtask

   task automatic test_round_robin();
      logic sd, ri, rd;
      int lat;
      bit to;
      logic [127:0] rdat, rsp;
      exp_t e;
      reset_dut();
      l1i_addr = 64'h2000; l1d_addr = 64'h3000;
      l1d_opcode = MEM_LD_CL; l1d_store_data = {8{16'hC0DE}};
      for (int j = 0; j < 4; j++) begin
         if (j % 2 == 0) sb.push_back(mk_exp(1'b1, 64'h3000, MEM_LD_CL, {8{16'hC0DE}}));
         else            sb.push_back(mk_exp(1'b0, 64'h2000, MEM_LD_CL, '0));
      end
      l1i_req = 1'b1; l1d_req = 1'b1;
      for (int j = 0; j < 4; j++) begin
         wait_ack(sd, lat, to);
         e = sb.pop_front();
         n_cmp++;
         if (to || sd !== e.side || lat != 2) begin
            n_bad++;
            $display("FAIL rr_grant%0d: side=%0d lat=%0d timeout=%0d want side=%0d lat=2", j, sd, lat, to, e.side);
         end
         n_cmp++;
         if (l2_req_addr !== e.addr || l2_req_opcode !== e.op || l2_req_store_data !== e.data) begin
            n_bad++;
            $display("FAIL rr_fields%0d: addr=%h op=%h data=%h want %h %h %h", j,
                     l2_req_addr, l2_req_opcode, l2_req_store_data, e.addr, e.op, e.data);
         end
         rsp = {4{$urandom()}};
         complete(j, rsp, ri, rd, rdat);
         if (j == 3) begin
            l1i_req = 1'b0; l1d_req = 1'b0;
         end
         n_cmp++;
         if (ri !== ~e.side || rd !== e.side || rdat !== rsp) begin
            n_bad++;
            $display("FAIL rr_rsp%0d: rspi=%b rspd=%b data=%h want %b %b %h", j, ri, rd, rdat, ~e.side, e.side, rsp);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (grants_i !== 32'd2 || grants_d !== 32'd2 || arb_idle !== 1'b1) begin
         n_bad++;
         $display("FAIL rr_counts: gi=%0d gd=%0d idle=%b want 2 2 1", grants_i, grants_d, arb_idle);
      end
   endtask

   task automatic test_writeback_stall();
      logic sd;
      int lat, unstable;
      bit to;
      exp_t e;
      tick();
      l1d_req = 1'b1; l1d_addr = 64'h4000; l1d_opcode = MEM_ST_CL; l1d_store_data = {16{8'h5A}};
      sb.push_back(mk_exp(1'b1, 64'h4000, MEM_ST_CL, {16{8'h5A}}));
      wait_ack(sd, lat, to);
      l1d_req = 1'b0;
      n_cmp++;
      if (to || sd !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_ack: side=%0d timeout=%0d want side=1", sd, to);
      end
      e = sb.pop_front();
      unstable = 0;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge clk);
         if (l2_req_valid !== 1'b1 || l2_req_addr !== e.addr || l2_req_opcode !== e.op || l2_req_store_data !== e.data)
            unstable++;
      end
      n_cmp++;
      if (unstable != 0) begin
         n_bad++;
         $display("FAIL wb_stable: %0d of 6 ISSUE cycles wrong (addr=%h op=%h) want 0", unstable, l2_req_addr, l2_req_opcode);
      end
      l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0;
      n_cmp++;
      if (l2_req_valid !== 1'b0 || arb_idle !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_wait: reqv=%b idle=%b want 0 0", l2_req_valid, arb_idle);
      end
      l2_rsp_valid = 1'b1; l2_rsp_data = {16{8'h33}};
      #1;
      n_cmp++;
      if (l1d_rsp_valid !== 1'b1 || l1i_rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_rsp: rspd=%b rspi=%b want 1 0", l1d_rsp_valid, l1i_rsp_valid);
      end
      tick();
      l2_rsp_valid = 1'b0;
      n_cmp++;
      if (grants_d !== 32'd3 || arb_idle !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_count: gd=%0d idle=%b want 3 1", grants_d, arb_idle);
      end
   endtask

   task automatic test_flush_hold();
      logic sd, ri, rd;
      int lat, bad_cycles;
      bit to;
      logic [127:0] rdat;
      reset_dut();
      flush_hold = 1'b1;
      l1i_req = 1'b1; l1d_req = 1'b1; l1i_addr = 64'h5000; l1d_addr = 64'h6000; l1d_opcode = MEM_LD_CL;
      bad_cycles = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (l1i_ack || l1d_ack || !arb_idle) bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles != 0) begin
         n_bad++;
         $display("FAIL flush_block: %0d cycles with ack or busy want 0", bad_cycles);
      end
      flush_hold = 1'b0;
      sb.push_back(mk_exp(1'b1, 64'h6000, MEM_LD_CL, '0));
      wait_ack(sd, lat, to);
      l1i_req = 1'b0; l1d_req = 1'b0;
      n_cmp++;
      if (to || sd !== sb[0].side || lat != 1 || l2_req_addr !== sb[0].addr) begin
         n_bad++;
         $display("FAIL flush_release: side=%0d lat=%0d timeout=%0d addr=%h want side=1 lat=1 addr=%h",
                  sd, lat, to, l2_req_addr, sb[0].addr);
      end
      void'(sb.pop_front());
      complete(0, {16{8'h11}}, ri, rd, rdat);
      n_cmp++;
      if (rd !== 1'b1 || ri !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_rsp: rspd=%b rspi=%b want 1 0", rd, ri);
      end
   endtask

   task automatic test_stray_rsp();
      n_cmp++;
      if (proto_err !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_pre: proto_err=%b want 0", proto_err);
      end
      l2_rsp_valid = 1'b1; l2_rsp_data = {16{8'hEE}};
      #1;
      n_cmp++;
      if (l1i_rsp_valid !== 1'b0 || l1d_rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stray_fwd: rspi=%b rspd=%b want 0 0", l1i_rsp_valid, l1d_rsp_valid);
      end
      tick();
      l2_rsp_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (proto_err !== 1'b1 || arb_idle !== 1'b1) begin
         n_bad++;
         $display("FAIL stray_sticky: proto_err=%b idle=%b want 1 1", proto_err, arb_idle);
      end
   endtask

   task automatic test_reset_mid();
      logic sd;
      int lat;
      bit to;
      reset_dut();
      l1i_req = 1'b1; l1i_addr = 64'h7000;
      wait_ack(sd, lat, to);
      l1i_req = 1'b0;
      l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0;
      n_cmp++;
      if (to || arb_idle !== 1'b0 || l2_req_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_setup: timeout=%0d idle=%b reqv=%b want 0 0 0", to, arb_idle, l2_req_valid);
      end
      #2;
      reset = 1'b1;
      l2_rsp_valid = 1'b1; l2_rsp_data = {16{8'h77}};
      #1;
      n_cmp++;
      if ({arb_idle, l1i_ack, l1d_ack, l2_req_valid, l1i_rsp_valid, l1d_rsp_valid, proto_err} !== 7'b1000000
          || grants_i !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_async: idle/acki/ackd/reqv/rspi/rspd/perr=%b gi=%0d want 1000000 0",
                  {arb_idle, l1i_ack, l1d_ack, l2_req_valid, l1i_rsp_valid, l1d_rsp_valid, proto_err}, grants_i);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      l2_rsp_valid = 1'b0;
      n_cmp++;
      if (proto_err !== 1'b1 || l1i_rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_late_rsp: proto_err=%b rspi=%b want 1 0", proto_err, l1i_rsp_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_i();
      test_round_robin();
      test_writeback_stall();
      test_flush_hold();
      test_stray_rsp();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/l1_l2_req_arb.md
# l1_l2_req_arb

Arbiter and sequencer for the single L1-to-L2 miss/writeback request channel, shared between the instruction cache and the data cache. It accepts line requests from both L1s and grants one at a time, round-robin, with at most one transaction outstanding. It latches the winning request and drives the L2 request port, then steers the L2 response back to the owning L1. It sits between the L1 caches and the L2, and is gated by the top-level flush sequencer through `flush_hold`.

## Interface
Parameters:
- `ADDR_W`, 64: address width (`M_WIDTH`).
- `CL_W`, 128: line data width (`1 << (LG_L2_CL_LEN+3)`).

Ports:
- `clk`  in  1  sole clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high.
- `l1i_req`  in  1  I-side request level.
- `l1i_addr`  in  ADDR_W  I-side line address.
- `l1i_ack`  out  1  one-cycle grant pulse to I-side.
- `l1i_rsp_valid`  out  1  I-side response strobe.
- `l1d_req`  in  1  D-side request level.
- `l1d_addr`  in  ADDR_W  D-side line address.
- `l1d_opcode`  in  4  D-side opcode (read line / write line).
- `l1d_store_data`  in  CL_W  D-side writeback data.
- `l1d_ack`  out  1  one-cycle grant pulse to D-side.
- `l1d_rsp_valid`  out  1  D-side response strobe.
- `l1_rsp_data`  out  CL_W  response data, shared by both sides.
- `l2_req_valid`  out  1  request to L2.
- `l2_req_addr`  out  ADDR_W  latched address.
- `l2_req_opcode`  out  4  latched opcode; I-side always `MEM_LD_CL`.
- `l2_req_store_data`  out  CL_W  latched data; zero for I-side.
- `l2_req_ready`  in  1  L2 accepts request.
- `l2_rsp_valid`  in  1  L2 response strobe.
- `l2_rsp_data`  in  CL_W  L2 response line.
- `flush_hold`  in  1  block new grants.
- `arb_idle`  out  1  no transaction in flight.
- `proto_err`  out  1  sticky protocol violation flag.
- `grants_i`  out  32  count of I-side grants.
- `grants_d`  out  32  count of D-side grants.

## Operation
- Three-state FSM:
  - `IDLE`:
    - If `!flush_hold` and any request is present, grant.
    - If only one side requests, that side wins.
    - If both request, the side not granted last wins. `last_grant` resets to I, so D wins the first tie.
    - On grant: latch address, opcode and data; set owner; go to `ISSUE`.
  - `ISSUE`: assert `l2_req_valid`. On `l2_req_ready`, go to `WAIT_RSP`.
  - `WAIT_RSP`: on `l2_rsp_valid`, assert `l1X_rsp_valid` for the owner (combinational from `l2_rsp_valid`), then go to `IDLE`.
- `l1X_ack` is registered and high for exactly the first cycle of `ISSUE`. The requester must drop `req` the cycle after it sees `ack`.
- `l1_rsp_data` is a combinational pass-through of `l2_rsp_data`.
- `grants_X` increments on each grant; it is a 32-bit counter that wraps modulo 2^32.
- `l2_rsp_valid` while in `IDLE` or `ISSUE` is ignored and sets `proto_err`. `proto_err` clears only on reset.
- `flush_hold` is sampled only in `IDLE`. It never aborts an in-flight transaction.
- `arb_idle` = (state == `IDLE`).

## Timing
- Reset values:
  - State `IDLE`, `last_grant` = I, owner = I.
  - All outputs 0, except `arb_idle` = 1.
  - Latched fields and counters 0.
  - Reset asserted mid-transaction discards it immediately; no response is forwarded.
- Request seen in `IDLE` at cycle 0:
  - Cycle 1: `ack` = 1 and `l2_req_valid` = 1.
  - `l2_req_ready` at cycle n (n ≥ 1): cycle n+1 is `WAIT_RSP`.
- Response at cycle k: `l1X_rsp_valid` at k; `IDLE` at k+1; the next grant is visible at k+2.
- Minimum transaction length is 3 cycles (`ISSUE`, `WAIT_RSP`, `IDLE`).
- `l2_req_*` fields are stable for all of `ISSUE`.
- `flush_hold` rising in the same cycle as a request in `IDLE`: no grant is made.

## Structure
- Shared package `l1_l2_arb_pkg`:
  - `arb_state_t` enum (`ARB_IDLE`=0, `ARB_ISSUE`=1, `ARB_WAIT_RSP`=2).
  - `arb_owner_t` enum (`OWN_I`=0, `OWN_D`=1).
  - `MEM_LD_CL` / `MEM_ST_CL` opcode constants, shared with the L1s and the L2.
- Single module, no sub-modules. The two-way round-robin pick is an inline function.

## Test plan
- Single I-side request, `l1i_addr`=0x1000:
  - `l1i_ack` at cycle 1; `l2_req_addr`=0x1000, opcode `MEM_LD_CL`.
  - `l2_rsp_valid` with data 0xAB.. gives `l1i_rsp_valid` with `l1_rsp_data`=0xAB.. the same cycle; `grants_i`=1.
- Simultaneous I and D requests from reset, repeated 4 times:
  - Grant order is D, I, D, I.
  - `grants_d`=2, `grants_i`=2; the non-owner `rsp_valid` is never asserted.
- D-side writeback with `MEM_ST_CL` and data 0x5A..5A, `l2_req_ready` held low for 5 cycles:
  - `l2_req_*` stable for all 6 cycles; `WAIT_RSP` is entered only after ready.
- `flush_hold`=1 with both requests pending for 10 cycles:
  - No ack; `arb_idle`=1.
  - Release: D-side ack 1 cycle later.
- Stray `l2_rsp_valid` in `IDLE`: `proto_err` goes to 1 and stays 1; no `rsp_valid` is asserted.
- Reset asserted in `WAIT_RSP`: `arb_idle`=1 and all strobes 0 with no clock edge; a later `l2_rsp_valid` sets `proto_err`.
